dac_interface: RTL and testbench

- Transmit-side counterpart of the ADC front end; drives a parallel 8-bit DAC for the signal-generator path.
- Sinks samples over the Simple Interface (SI_data/SI_rdy/SI_ack) into a small FIFO.
- Replays samples to the DAC, one per divided-clock period, and generates the DAC clock from clk_i.
- Flags underrun when the DAC needs a sample and none is buffered.

---
 rtl/dac_interface.sv | 101 ++++++++++
 tb/tb_dac_interface.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dac_interface.sv
// Parallel DAC driver: buffers Simple Interface samples in a small FIFO and
// replays them to the DAC, one per DAC_clk period. DAC_clk is clk_i itself
// (bypass) or a divided clock. Sticky underrun flag when a sample is due
// but none is buffered.
module dac_interface #(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 32,
  parameter int FIFO_AW       = 2
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    SI_data,
  input  logic                     SI_rdy,
  output logic                     SI_ack,
  output logic [DATA_WIDTH-1:0]    DAC_data,
  output logic                     DAC_clk,
  input  logic                     enable,
  input  logic [CLK_DIV_WIDTH-1:0] decimation_factor,
  output logic                     underrun,
  input  logic                     underrun_clr,
  output logic [FIFO_AW:0]         fill_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr, rd_ptr;
  logic [FIFO_AW:0]         count;
  logic [CLK_DIV_WIDTH-1:0] counter, last_cnt;
  logic div, primed;
  logic bypass, at_last, upd, push, pop, empty, full;

  assign bypass   = (decimation_factor == '0);
  assign last_cnt = decimation_factor - CLK_DIV_WIDTH'(1);
  assign at_last  = (counter == last_cnt);
  assign empty    = (count == '0);
  assign full     = (count == (FIFO_AW+1)'(DEPTH));

  // Ready is independent of SI_rdy; a pop in the same cycle does not free a slot.
  assign SI_ack = !rst && enable && !full;
  assign push   = SI_rdy && SI_ack;

  // Update on the DAC_clk falling edge so the DAC sees half a period of setup.
  assign upd = enable && (bypass || (at_last && div));
  assign pop = upd && !empty;

  assign DAC_clk    = (rst || !enable) ? 1'b0 : (bypass ? clk_i : div);
  assign fill_level = count;

  // Divider: wraps on ">=" so a shrinking decimation_factor never runs the
  // counter through its full range; only an exact last count toggles div.
  always_ff @(posedge clk_i) begin
    if (rst || !enable || bypass) begin
      counter <= '0;
      div     <= 1'b0;
    end else if (counter >= last_cnt) begin
      counter <= '0;
      if (at_last) div <= ~div;
    end else begin
      counter <= counter + CLK_DIV_WIDTH'(1);
    end
  end

  // FIFO storage; contents need no reset since count gates all reads.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= SI_data;
  end

  // FIFO pointers and occupancy; disabling flushes the buffer.
  always_ff @(posedge clk_i) begin
    if (rst || !enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Output register, priming and sticky underrun (set beats clear).
  always_ff @(posedge clk_i) begin
    if (rst) begin
      DAC_data <= '0;
      primed   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (pop) DAC_data <= mem[rd_ptr];
      if (!enable)  primed <= 1'b0;
      else if (pop) primed <= 1'b1;
      if (upd && empty && primed) underrun <= 1'b1;
      else if (underrun_clr)      underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_interface.sv
// Scoreboard bench for dac_interface: the stimulus process runs a queue-based
// reference model and pushes the expected post-edge state; a monitor pops
// and compares after every clk_i rising edge.
module tb_dac_interface;

  localparam int DW    = 8;
  localparam int CW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] SI_data = '0;
  logic          SI_rdy = 1'b0;
  logic          SI_ack;
  logic [DW-1:0] DAC_data;
  logic          DAC_clk;
  logic          enable = 1'b0;
  logic [CW-1:0] decimation_factor = '0;
  logic          underrun;
  logic          underrun_clr = 1'b0;
  logic [AW:0]   fill_level;

  dac_interface #(.DATA_WIDTH(DW), .CLK_DIV_WIDTH(CW), .FIFO_AW(AW)) dut (
    .clk_i(clk_i), .rst(rst), .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
    .DAC_data(DAC_data), .DAC_clk(DAC_clk), .enable(enable),
    .decimation_factor(decimation_factor), .underrun(underrun),
    .underrun_clr(underrun_clr), .fill_level(fill_level)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW-1:0] dac;
    logic          und;
    int            fill;
    logic          ack;
    logic          dclk;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dac = '0;
  logic          m_und = 1'b0;
  logic          m_primed = 1'b0;
  int            m_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clk_i cycle: drive inputs at negedge, advance the model, queue expectation.
  task automatic cyc(input bit r, input bit e, input int unsigned d,
                     input bit rdy, input logic [DW-1:0] data, input bit clr);
    bit   ack, upd, set_und;
    exp_t x;
    @(negedge clk_i);
    rst = r; enable = e; decimation_factor = d; SI_rdy = rdy; SI_data = data;
    underrun_clr = clr;
    if (r) begin
      mq.delete(); m_dac = '0; m_und = 1'b0; m_primed = 1'b0; m_t = 0;
    end else if (!e) begin
      mq.delete(); m_primed = 1'b0; m_t = 0;
    end else begin
      ack     = (mq.size() < DEPTH);
      upd     = (d == 0) || ((m_t % (2 * d)) == (2 * d - 1));
      set_und = upd && (mq.size() == 0) && m_primed;
      m_t++;
      if (upd && mq.size() > 0) begin
        m_dac    = mq.pop_front();
        m_primed = 1'b1;
      end
      m_und = set_und ? 1'b1 : (clr ? 1'b0 : m_und);
      if (ack && rdy) mq.push_back(data);
    end
    x.dac  = m_dac;
    x.und  = m_und;
    x.fill = mq.size();
    x.ack  = !r && e && (mq.size() < DEPTH);
    x.dclk = (r || !e) ? 1'b0 : ((d == 0) ? 1'b1 : 1'((m_t / d) % 2));
    sb.push_back(x);
  endtask

  // Monitor: compare DUT state just after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("dac_data", 32'(DAC_data), 32'(x.dac));
        chk("underrun", 32'(underrun), 32'(x.und));
        chk("fill_level", 32'(fill_level), 32'(x.fill));
        chk("si_ack", 32'(SI_ack), 32'(x.ack));
        chk("dac_clk", 32'(DAC_clk), 32'(x.dclk));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] seq4 [4];
    int unsigned dfs [6];
    int unsigned d, thr;
    int rise_cnt, first_rise, second_rise;
    logic prev_clk;
    seq4 = '{8'h10, 8'h20, 8'h30, 8'h40};
    dfs  = '{0, 1, 2, 3, 4, 7};

    // Reset with SI_rdy held high
    repeat (3) cyc(1, 1, 2, 1, 8'hAA, 0);

    // Divide-by-2 replay of a short stream, then underrun and its clear
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 1, seq4[i], 0);
    repeat (30) cyc(0, 1, 2, 0, 8'h00, 0);
    cyc(0, 1, 2, 0, 8'h00, 1);
    repeat (3) cyc(0, 1, 2, 0, 8'h00, 0);

    // Never-primed run must not flag underrun
    repeat (2) cyc(0, 0, 1, 0, 8'h00, 0);
    cyc(0, 1, 1, 0, 8'h00, 1);
    repeat (10) cyc(0, 1, 1, 0, 8'h00, 0);

    // Fill to full with a slow divider
    repeat (2) cyc(0, 0, 100, 0, 8'h00, 0);
    for (int i = 0; i < 210; i++) cyc(0, 1, 100, 1, 8'(8'h50 + i), 0);

    // Bypass stream 0..7
    repeat (2) cyc(0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, 8'(i), 0);
    repeat (2) cyc(0, 0, 0, 0, 8'h00, 0);

    // Randomised segments: divider changes only while disabled
    for (int s = 0; s < 25; s++) begin
      d   = dfs[$urandom_range(0, 5)];
      thr = $urandom_range(1, 4);
      repeat (2) cyc(0, 0, d, 0, 8'h00, 0);
      for (int i = 0; i < int'($urandom_range(20, 80)); i++) begin
        if ($urandom_range(0, 99) == 0)
          cyc(1, 1, d, 1, 8'($urandom), 0);
        else if ($urandom_range(0, 39) == 0)
          cyc(0, 0, d, 1, 8'($urandom), 0);
        else
          cyc(0, 1, d, ($urandom_range(0, 3) < thr), 8'($urandom),
              ($urandom_range(0, 15) == 0));
      end
    end
    repeat (3) cyc(0, 0, 2, 0, 8'h00, 0);

    // Divider shrink mid-period: 10 -> 2 while the counter sits at 7
    @(negedge clk_i);
    enable = 1'b1; decimation_factor = 10; SI_rdy = 1'b0; underrun_clr = 1'b0;
    repeat (7) @(posedge clk_i);
    @(negedge clk_i);
    decimation_factor = 2;
    rise_cnt = 0; first_rise = -1; second_rise = -1;
    prev_clk = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_i);
      #1;
      if (DAC_clk && !prev_clk) begin
        if (rise_cnt == 0) first_rise = c;
        else if (rise_cnt == 1) second_rise = c;
        rise_cnt++;
      end
      prev_clk = DAC_clk;
    end
    chk("shrink_first_rise_in_bound", 32'(first_rise > 0 && first_rise <= 4), 32'd1);
    chk("shrink_period", 32'(second_rise - first_rise), 32'd4);

    @(negedge clk_i);
    enable = 1'b0;
    repeat (2) @(posedge clk_i);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
